// File: rtl/pll_clkgen.sv
// Digital stand-in for the board PLL: four counter-based clock dividers plus a sticky lock flag.
// Optional feature: define PLL_CLKOUT_GATE_EN to hold the dividers frozen and low until lock.
module pll_clkgen #(
   parameter int DIV0        = 2,
   parameter int DIV1        = 4,
   parameter int DIV2        = 5,
   parameter int DIV3        = 10,
   parameter int LOCK_CYCLES = 1024
) (
   input  logic clkin1,
   input  logic rst_n,
   output logic clkout0,
   output logic clkout1,
   output logic clkout2,
   output logic clkout3,
   output logic pll_lock
);

   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_CYCLES);
   localparam int DIV_TAB [4] = '{DIV0, DIV1, DIV2, DIV3};

   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic          pll_lock_q, pll_lock_d;
   logic [3:0]    clkout_q, clkout_d;
   logic          div_en;

   // ------------------------------------------------------------------
   // Lock counter: counts up while unlocked and saturates at LOCK_CYCLES.
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      lock_cnt_d = lock_cnt_q;
      pll_lock_d = pll_lock_q;
      if (!pll_lock_q) begin
         if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
         if (lock_cnt_q == LOCK_LAST) pll_lock_d = 1'b1;
      end
   end

   // NOTE: asynchronous active-low reset in the sensitivity list; state flops use non-blocking (<=) only.
   always_ff @(posedge clkin1 or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt_q <= '0;
         pll_lock_q <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         pll_lock_q <= pll_lock_d;
      end
   end

`ifdef PLL_CLKOUT_GATE_EN
   assign div_en = pll_lock_q;
`else
   assign div_en = 1'b1;
`endif

   // ------------------------------------------------------------------
   // Dividers: the output flop captures (count < DIV/2) on the same edge
   // the count advances, so each clkout is a bare flop output.
   // ------------------------------------------------------------------
   for (genvar n = 0; n < 4; n++) begin : g_div
      localparam int DIV = DIV_TAB[n];
      localparam int W   = $clog2(DIV);
      localparam logic [W-1:0] LAST = W'(DIV - 1);
      localparam logic [W-1:0] HALF = W'(DIV / 2);

      logic [W-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d       = cnt_q;
         clkout_d[n] = clkout_q[n];
         if (div_en) begin
            clkout_d[n] = (cnt_q < HALF);
            cnt_d       = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clkin1 or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q       <= '0;
            clkout_q[n] <= 1'b0;
         end else begin
            cnt_q       <= cnt_d;
            clkout_q[n] <= clkout_d[n];
         end
      end
   end

   assign clkout0  = clkout_q[0];
   assign clkout1  = clkout_q[1];
   assign clkout2  = clkout_q[2];
   assign clkout3  = clkout_q[3];
   assign pll_lock = pll_lock_q;

endmodule

// File: tb/tb_pll_clkgen.sv
// Bench for pll_clkgen: default instance plus a LOCK_CYCLES=2 / DIV0=3 instance, checked every cycle
// against an edge-count model; honours PLL_CLKOUT_GATE_EN the same way as the design.
module tb_pll_clkgen;

   logic clk;
   logic rst_n;
   logic clkout0, clkout1, clkout2, clkout3, pll_lock;
   logic s_clkout0, s_clkout1, s_clkout2, s_clkout3, s_lock;

   int total = 0;
   int bad   = 0;
   int e     = 0;            // rising edges since reset release
   int rises = 0, s_rises = 0;
   logic lock_prev = 1'b0, s_lock_prev = 1'b0;

   pll_clkgen dut (
      .clkin1(clk), .rst_n(rst_n),
      .clkout0(clkout0), .clkout1(clkout1), .clkout2(clkout2), .clkout3(clkout3),
      .pll_lock(pll_lock)
   );

   pll_clkgen #(.LOCK_CYCLES(2), .DIV0(3)) dut_s (
      .clkin1(clk), .rst_n(rst_n),
      .clkout0(s_clkout0), .clkout1(s_clkout1), .clkout2(s_clkout2), .clkout3(s_clkout3),
      .pll_lock(s_lock)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   always @(posedge clk) if (rst_n) e = e + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected divider output after edge e for a block that locks at edge lc.
   function automatic int exp_out(input int ee, input int lc, input int div);
      int a;
`ifdef PLL_CLKOUT_GATE_EN
      a = ee - lc;
`else
      a = ee;
      if (lc < 0) a = ee;   // lock timing does not affect ungated outputs
`endif
      if (a < 1) return 0;
      return (((a - 1) % div) < (div / 2)) ? 1 : 0;
   endfunction

   function automatic int exp_lock(input int ee, input int lc);
      return (ee >= lc) ? 1 : 0;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_main", {clkout3, clkout2, clkout1, clkout0, pll_lock}, 0);
         check("rst_small", {s_clkout3, s_clkout2, s_clkout1, s_clkout0, s_lock}, 0);
         lock_prev   = 1'b0;
         s_lock_prev = 1'b0;
      end else begin
         check($sformatf("lock e=%0d", e), pll_lock, exp_lock(e, 1024));
         check($sformatf("clkout0 e=%0d", e), clkout0, exp_out(e, 1024, 2));
         check($sformatf("clkout1 e=%0d", e), clkout1, exp_out(e, 1024, 4));
         check($sformatf("clkout2 e=%0d", e), clkout2, exp_out(e, 1024, 5));
         check($sformatf("clkout3 e=%0d", e), clkout3, exp_out(e, 1024, 10));
         check($sformatf("s_lock e=%0d", e), s_lock, exp_lock(e, 2));
         check($sformatf("s_clkout0 e=%0d", e), s_clkout0, exp_out(e, 2, 3));
         check($sformatf("s_clkout3 e=%0d", e), s_clkout3, exp_out(e, 2, 10));
         if (pll_lock && !lock_prev) rises++;
         if (s_lock && !s_lock_prev) s_rises++;
         lock_prev   = pll_lock;
         s_lock_prev = s_lock;
      end
   end

   task automatic wait_e(input int target);
      int n;
      n = 0;
      while (e != target && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (e != target) check("wait_e_timeout", e, target);
   endtask

   function automatic logic get_out(input int idx);
      case (idx)
         0:       return clkout0;
         1:       return clkout1;
         2:       return clkout2;
         3:       return clkout3;
         default: return s_clkout0;
      endcase
   endfunction

   // Polls on odd ns (away from the edges at 10 mod 20) and times one full output period.
   task automatic measure(input string name, input int idx, input int period, input int high);
      time t0, t1, t2;
      int  n;
      n = 0;
      #1;
      while (get_out(idx) != 1'b0 && n < 1000) begin #2; n++; end
      while (get_out(idx) != 1'b1 && n < 1000) begin #2; n++; end
      t0 = $time;
      while (get_out(idx) != 1'b0 && n < 1000) begin #2; n++; end
      t1 = $time;
      while (get_out(idx) != 1'b1 && n < 1000) begin #2; n++; end
      t2 = $time;
      check({name, "_timeout"}, int'(n < 1000), 1);
      check({name, "_period_ns"}, int'(t2 - t0), period);
      check({name, "_high_ns"}, int'(t1 - t0), high);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #5 rst_n = 1'b0;
      e       = 0;
      rises   = 0;
      s_rises = 0;
      #1;
      check("midrst_main_now", {clkout3, clkout2, clkout1, clkout0, pll_lock}, 0);
      check("midrst_small_now", {s_clkout3, s_clkout2, s_clkout1, s_clkout0, s_lock}, 0);
      #29 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #4;
      check("por_main", {clkout3, clkout2, clkout1, clkout0, pll_lock}, 0);
      check("por_small", {s_clkout3, s_clkout2, s_clkout1, s_clkout0, s_lock}, 0);
      #20 rst_n = 1'b1;

      wait_e(1);
      check("s_lock_edge1", s_lock, 0);
`ifdef PLL_CLKOUT_GATE_EN
      check("clkout0_edge1_gated", clkout0, 0);
`else
      check("clkout0_edge1", clkout0, 1);
`endif
      wait_e(2);
      check("s_lock_edge2", s_lock, 1);
`ifndef PLL_CLKOUT_GATE_EN
      check("clkout0_edge2", clkout0, 0);
      measure("pre_lock_clkout0", 0, 40, 20);
`endif
      wait_e(1023);
      check("lock_edge1023", pll_lock, 0);
      wait_e(1024);
      check("lock_edge1024", pll_lock, 1);
`ifdef PLL_CLKOUT_GATE_EN
      check("all_low_at_lock", {clkout3, clkout2, clkout1, clkout0}, 0);
      wait_e(1025);
      check("all_rise_after_lock", {clkout3, clkout2, clkout1, clkout0}, 4'hf);
      wait_e(1045);
      check("all_high_again", {clkout3, clkout2, clkout1, clkout0}, 4'hf);
`endif
      wait_e(1050); measure("clkout0", 0, 40, 20);
      wait_e(e + 2); measure("clkout1", 1, 80, 40);
      wait_e(e + 2); measure("clkout2", 2, 100, 40);
      wait_e(e + 2); measure("clkout3", 3, 200, 100);
      wait_e(e + 2); measure("s_clkout0", 4, 60, 20);
      wait_e(1400);
      check("lock_rises_por", rises, 1);
      check("s_lock_rises_por", s_rises, 1);

      pulse_reset();
      wait_e(1023);
      check("relock_edge1023", pll_lock, 0);
      wait_e(1024);
      check("relock_edge1024", pll_lock, 1);
      wait_e(1300);
      check("lock_rises_relock", rises, 1);
      check("s_lock_rises_relock", s_rises, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
